keypad_timer_ctrl: RTL

KEYPAD_TIMER_CTRL -- requirements
Module: keypad_timer_ctrl

---
 rtl/keypad_timer_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_timer_ctrl.sv
// keypad_timer_ctrl
// Front-end controller for a microwave-style countdown timer. It debounces
// keypad edges into single presses, feeds entered digits to the downstream
// countdown load chain, and sequences the IDLE / ENTRY / COOKING / PAUSED
// modes that gate the countdown enable and the magnetron drive.
module keypad_timer_ctrl #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [9:0] keypad,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       zero,
    input  logic       tick,
    output logic [3:0] data,
    output logic       loadn,
    output logic       cnt_clrn,
    output logic       enable,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state
);

    // Digit counter must be able to hold MAX_DIGITS itself.
    localparam int CW = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ENTRY = 2'b01,
        ST_COOK  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [9:0]      r_kp_p0;       // keypad as seen last cycle, for edge detect
    logic [CW-1:0]   r_cnt;         // digits accepted in the current entry
    logic [3:0]      r_code_p0;     // code of the press accepted last edge
    logic            r_load_p0;     // a press was accepted last edge
    logic [3:0]      r_data_p1;
    logic            r_loadn_p1;
    logic            r_cnt_clrn;
    logic            r_mag_on;
    logic            r_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t          w_next;
    logic            w_press;
    logic [3:0]      w_code;
    logic            w_room;
    logic            w_key_state;
    logic            w_accept;
    logic            w_start_ok;
    logic            w_pause;
    logic            w_clr_req;
    logic            w_done_nxt;
    logic            w_cnt_clrn_nxt;
    logic            w_mag_nxt;

    // A press is the first cycle a nonzero keypad follows an all-zero one.
    assign w_press = (|keypad) & ~(|r_kp_p0);

    // Priority encoder: lowest pressed digit wins on multi-key presses.
    always_comb begin
        w_code = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (keypad[i]) begin
                w_code = 4'(i);
            end
        end
    end

    assign w_room      = (r_cnt < CW'(MAX_DIGITS));
    assign w_key_state = (r_state == ST_IDLE) || (r_state == ST_ENTRY);

    // Clear wins over a simultaneous key press.
    assign w_accept    = w_press & w_key_state & w_room & ~clear;

    // Start is honoured only when nothing vetoes it; stop beats start.
    assign w_start_ok  = start & ~stop & ~clear & door_closed & ~zero;

    // Any of these suspends an active cook.
    assign w_pause     = stop | clear | ~door_closed;

    // Clear resets the countdown everywhere except while cooking, where it
    // only pauses.
    assign w_clr_req   = clear & (r_state != ST_COOK);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_next = ST_IDLE;
                end else if (w_accept) begin
                    w_next = ST_ENTRY;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (clear) begin
                    w_next = ST_IDLE;
                end else if (w_start_ok) begin
                    w_next = ST_COOK;
                end else begin
                    w_next = ST_ENTRY;
                end
            end
            ST_COOK: begin
                if (w_pause) begin
                    w_next = ST_PAUSE;
                end else if (zero) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_COOK;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    w_next = ST_IDLE;
                end else if (w_start_ok) begin
                    w_next = ST_COOK;
                end else begin
                    w_next = ST_PAUSE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode: next values for registered outputs, plus live enable.
    always_comb begin
        w_done_nxt     = (r_state == ST_COOK) & ~w_pause & zero;
        w_cnt_clrn_nxt = ~w_clr_req;
        w_mag_nxt      = (w_next == ST_COOK);
        enable         = (r_state == ST_COOK) & tick & door_closed
                         & ~zero & ~stop & ~clear;
    end

    // ------------------------------------------------------------------
    // Keypad edge history and digit counter
    // ------------------------------------------------------------------

    // Track last keypad level and count digits; the count restarts whenever
    // the controller lands in IDLE.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_kp_p0 <= 10'd0;
            r_cnt   <= '0;
        end else begin
            r_kp_p0 <= keypad;
            if (w_next == ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_accept && w_room) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: capture accepted press
    // ------------------------------------------------------------------

    // Hold the accepted code one cycle before it is presented downstream.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_code_p0 <= 4'd0;
            r_load_p0 <= 1'b0;
        end else begin
            r_load_p0 <= w_accept;
            if (w_accept) begin
                r_code_p0 <= w_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: present digit and load strobe
    // ------------------------------------------------------------------

    // data changes only with a new load so the countdown sees a stable digit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_data_p1  <= 4'd0;
            r_loadn_p1 <= 1'b1;
        end else begin
            r_loadn_p1 <= ~r_load_p0;
            if (r_load_p0) begin
                r_data_p1 <= r_code_p0;
            end
        end
    end

    // Register the control strobes so they are glitch-free at the countdown.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt_clrn <= 1'b1;
            r_mag_on   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt_clrn <= w_cnt_clrn_nxt;
            r_mag_on   <= w_mag_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign data     = r_data_p1;
    assign loadn    = r_loadn_p1;
    assign cnt_clrn = r_cnt_clrn;
    assign mag_on   = r_mag_on;
    assign done     = r_done;
    assign state    = r_state;

endmodule
